// File: rtl/dram2videoaxis.sv
// Frame reader: issues burst read commands to a DRAM read controller, buffers the
// returned words in a FIFO and plays them out as one AXI4-Stream video frame.
// Memory layout: one 32-bit word per pixel, {R,G,B,8'hff}, lines contiguous from BASE_ADDR.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start / busy          frame trigger pulse / frame in progress
//   overflow              sticky: a returned word was dropped because the FIFO was full
//   ctrl_out/ctrl_we      read command {len[39:32], byte addr[31:0]} and its strobe
//   ctrl_full             controller command queue full
//   rdata_in/rdata_valid  returned read data, in command order
//   m_axis_*              video stream out (tuser = start of frame, tlast = end of line)
module dram2videoaxis #(
  parameter int unsigned WIDTH      = 1920,
  parameter int unsigned HEIGHT     = 1080,
  parameter int unsigned BURST      = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        overflow,
  output logic [39:0] ctrl_out,
  output logic        ctrl_we,
  input  logic        ctrl_full,
  input  logic [31:0] rdata_in,
  input  logic        rdata_valid,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast
);

  localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned LW        = 12;
  localparam int unsigned MEM_WORDS = 1 << AW;

  localparam logic [LW-1:0] W_L       = LW'(WIDTH);
  localparam logic [LW-1:0] B_L       = LW'(BURST);
  localparam logic [LW-1:0] LAST_PIX  = LW'(WIDTH - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic          W_ONE     = (WIDTH == 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT} state_t;

  state_t         state, state_nxt;
  logic [LW-1:0]  col, cmd_line, pix, line;
  logic [31:0]    addr;
  logic [CW-1:0]  outstanding, count;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [23:0]    mem [MEM_WORDS];

  logic [LW-1:0]  remain_c;
  logic [7:0]     len_c;
  logic           line_end_c, last_cmd_c, credit_c;
  logic           start_c, issue_c;
  logic           full_c, load_c, pop_c, bypass_c, push_c;
  logic           fire_c, frame_done_c;
  logic           unused_alpha;

  // Low byte of each word is the constant alpha and is never displayed.
  assign unused_alpha = ^rdata_in[7:0];

  // Next command length: full burst, or the remainder of the current line.
  always_comb begin
    remain_c   = W_L - col;
    len_c      = (remain_c > B_L) ? 8'(BURST) : 8'(remain_c);
    line_end_c = (col + LW'(len_c)) == W_L;
    last_cmd_c = line_end_c && (cmd_line == LAST_LINE);
    // Credit counts words in flight plus words buffered, so pushes can never overflow.
    credit_c   = (32'(outstanding) + 32'(count) + 32'(len_c)) <= 32'(FIFO_DEPTH);
  end

  // Stream-side handshakes and FIFO movement.
  always_comb begin
    fire_c       = m_axis_tvalid && m_axis_tready;
    frame_done_c = fire_c && m_axis_tlast && (line == LAST_LINE);
    full_c       = (count == DEPTH_C);
    load_c       = !m_axis_tvalid || m_axis_tready;
    pop_c        = load_c && (count != '0);
    // Empty FIFO: a returning word goes straight to the output register.
    bypass_c     = load_c && (count == '0) && rdata_valid;
    push_c       = rdata_valid && !full_c && !bypass_c;
  end

  // Command FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Command FSM next state and decisions.
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    issue_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_c   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!ctrl_full && credit_c) begin
          issue_c   = 1'b1;
          state_nxt = last_cmd_c ? S_WAIT : S_GAP;
        end
      end
      S_GAP:  state_nxt = S_ISSUE;
      S_WAIT: if (frame_done_c) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command address/position tracking and registered command port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col         <= '0;
      cmd_line    <= '0;
      addr        <= '0;
      ctrl_out    <= '0;
      ctrl_we     <= 1'b0;
      outstanding <= '0;
    end else begin
      ctrl_we     <= issue_c;
      outstanding <= outstanding + (issue_c ? CW'(len_c) : CW'(0)) - CW'(rdata_valid);
      if (start_c) begin
        col      <= '0;
        cmd_line <= '0;
        addr     <= BASE_ADDR;
      end else if (issue_c) begin
        ctrl_out <= {len_c, addr};
        addr     <= addr + {22'd0, len_c, 2'b00};
        if (line_end_c) begin
          col      <= '0;
          cmd_line <= cmd_line + LW'(1);
        end else begin
          col <= col + LW'(len_c);
        end
      end
    end
  end

  // Busy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (start_c)           busy <= 1'b1;
      else if (frame_done_c) busy <= 1'b0;
      if (start_c)                     overflow <= 1'b0;
      else if (rdata_valid && full_c)  overflow <= 1'b1;
    end
  end

  // FIFO storage (no reset needed; pointers qualify contents).
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= rdata_in[31:8];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_c) - CW'(pop_c);
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (pop_c) begin
      m_axis_tdata  <= mem[rd_ptr];
      m_axis_tvalid <= 1'b1;
    end else if (bypass_c) begin
      m_axis_tdata  <= rdata_in[31:8];
      m_axis_tvalid <= 1'b1;
    end else if (fire_c) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Pixel/line position of the beat on the bus; tuser/tlast precomputed from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix          <= '0;
      line         <= '0;
      m_axis_tuser <= 1'b0;
      m_axis_tlast <= 1'b0;
    end else if (start_c) begin
      pix          <= '0;
      line         <= '0;
      m_axis_tuser <= 1'b1;
      m_axis_tlast <= W_ONE;
    end else if (fire_c) begin
      m_axis_tuser <= 1'b0;
      if (pix == LAST_PIX) begin
        pix          <= '0;
        line         <= (line == LAST_LINE) ? '0 : line + LW'(1);
        m_axis_tlast <= W_ONE && !frame_done_c;
      end else begin
        pix          <= pix + LW'(1);
        m_axis_tlast <= (pix + LW'(1)) == LAST_PIX;
      end
    end
  end

endmodule

// File: tb/tb_dram2videoaxis.sv
// Self-checking bench for dram2videoaxis: a DRAM responder model, a reference
// frame plan (commands and beats) computed from the address layout, and
// decoupled monitors on the command port and the video stream.
module tb_dram2videoaxis;

  localparam int W     = 10;
  localparam int H     = 3;
  localparam int B     = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'hFFFF_FFE0;  // frame wraps past 2^32

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ctrl_full = 1'b0;
  logic [31:0] rdata_in = '0;
  logic        rdata_valid = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic        busy, overflow, ctrl_we;
  logic [39:0] ctrl_out;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;

  dram2videoaxis #(
    .WIDTH(W), .HEIGHT(H), .BURST(B), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .overflow(overflow),
    .ctrl_out(ctrl_out), .ctrl_we(ctrl_we), .ctrl_full(ctrl_full),
    .rdata_in(rdata_in), .rdata_valid(rdata_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        fin;
  } beat_t;

  beat_t       exp_beat[$];
  logic [39:0] exp_cmd[$];
  logic [31:0] rq[$];
  int errors = 0;
  int checks = 0;
  int cmd_seen = 0;
  int beats_seen = 0;
  int resp_pct = 100;
  int tready_mode = 1;   // 0 low, 1 high, 2 random, 3 high except on the final beat
  int extra = 0;
  bit ovf_allowed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[25:2] ^ 24'h5AC396, 8'hff};
  endfunction

  // Reference plan of one frame from the memory layout.
  task automatic plan_frame();
    int n;
    logic [31:0] w;
    beat_t b;
    for (int l = 0; l < H; l++) begin
      for (int off = 0; off < W; off += B) begin
        n = (W - off < B) ? W - off : B;
        exp_cmd.push_back({8'(n), BASE + 32'(4 * (l * W + off))});
      end
    end
    for (int k = 0; k < W * H; k++) begin
      w      = word_at(BASE + 32'(4 * k));
      b.data = w[31:8];
      b.user = (k == 0);
      b.last = (k % W == W - 1);
      b.fin  = (k == W * H - 1);
      exp_beat.push_back(b);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_beat.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got beats_left=%0d expected 0", name, exp_beat.size());
    end
    check({name, "_cmds_left"}, 64'(exp_cmd.size()), 64'd0);
  endtask

  // DRAM responder: returns words in command order, flushed by reset.
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      rq.delete();
      rdata_valid = 1'b0;
    end else if (rq.size() > 0 && $urandom_range(99) < resp_pct) begin
      rdata_valid = 1'b1;
      rdata_in    = word_at(rq.pop_front());
    end else if (extra > 0) begin
      rdata_valid = 1'b1;
      rdata_in    = 32'hDEAD00FF;
      extra--;
    end else begin
      rdata_valid = 1'b0;
    end
  end

  // Sink ready driver.
  initial forever begin
    @(posedge clk); #1;
    case (tready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      2:       m_axis_tready = 1'($urandom_range(1));
      default: m_axis_tready = (exp_beat.size() != 1);
    endcase
  end

  // Command port monitor.
  logic        prev_we = 1'b0, prev_full = 1'b0;
  logic [39:0] last_out = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = '0;
    end else if (ctrl_we) begin
      cmd_seen++;
      check("cmd_gap", 64'(prev_we), 64'd0);
      check("cmd_while_full", 64'(prev_full), 64'd0);
      if (exp_cmd.size() == 0) begin
        checks++; errors++;
        $display("FAIL cmd_extra: got %h expected none", ctrl_out);
      end else begin
        check("cmd", 64'(ctrl_out), 64'(exp_cmd.pop_front()));
      end
      for (int i = 0; i < int'(ctrl_out[39:32]); i++) rq.push_back(ctrl_out[31:0] + 32'(4 * i));
      last_out = ctrl_out;
    end else begin
      check("ctrl_hold", 64'(ctrl_out), 64'(last_out));
    end
    prev_we   = ctrl_we;
    prev_full = ctrl_full;
  end

  // Stream monitor / scoreboard.
  bit          prev_stall = 1'b0, expect_idle = 1'b0;
  logic [25:0] prev_bits = '0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall  = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (!ovf_allowed) check("overflow_clear", 64'(overflow), 64'd0);
      if (expect_idle) begin
        check("busy_drop", 64'(busy), 64'd0);
        expect_idle = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_stable", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(prev_bits));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_beat.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_extra: got %h expected none", m_axis_tdata);
        end else begin
          e = exp_beat.pop_front();
          check($sformatf("tdata[%0d]", beats_seen), 64'(m_axis_tdata), 64'(e.data));
          check($sformatf("tuser[%0d]", beats_seen), 64'(m_axis_tuser), 64'(e.user));
          check($sformatf("tlast[%0d]", beats_seen), 64'(m_axis_tlast), 64'(e.last));
          check("busy_during_beat", 64'(busy), 64'd1);
          if (e.fin) expect_idle = 1'b1;
        end
        beats_seen++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_bits  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, b0;
    bit hit;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 64'({busy, overflow, ctrl_we, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'd0);
    check("reset_ctrl_out", 64'(ctrl_out), 64'd0);
    rst_n = 1'b1;

    // Plain frame, sink always ready.
    plan_frame();
    pulse_start();
    check("busy_set", 64'(busy), 64'd1);
    wait_frame_done("t1");

    // Random sink backpressure and slow responder.
    tready_mode = 2; resp_pct = 60;
    plan_frame();
    pulse_start();
    wait_frame_done("t2");

    // Controller full for 50 cycles after start.
    tready_mode = 1; resp_pct = 100;
    @(posedge clk); #1 ctrl_full = 1'b1;
    c0 = cmd_seen;
    plan_frame();
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    check("no_cmd_while_full", 64'(cmd_seen - c0), 64'd0);
    ctrl_full = 1'b0;
    wait_frame_done("t3");

    // Credit stall with sink blocked.
    @(negedge clk); tready_mode = 0;
    c0 = cmd_seen;
    plan_frame();
    pulse_start();
    repeat (100) @(negedge clk);
    check("credit_cmds", 64'(cmd_seen - c0), 64'd2);
    check("credit_hold_valid", 64'(m_axis_tvalid), 64'd1);
    tready_mode = 1;
    wait_frame_done("t4");

    // Start while busy is ignored.
    plan_frame();
    pulse_start();
    repeat (15) @(posedge clk);
    check("busy_mid", 64'(busy), 64'd1);
    pulse_start();
    wait_frame_done("t5");

    // Start in the same cycle as the final beat is ignored.
    @(negedge clk); tready_mode = 3;
    plan_frame();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (exp_beat.size() == 1 && m_axis_tvalid) hit = 1'b1;
    end
    check("t6_reach_last", 64'(hit), 64'd1);
    tready_mode = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cmd_seen;
    repeat (20) @(negedge clk);
    check("t6_no_restart_cmds", 64'(cmd_seen - c0), 64'd0);
    check("t6_idle", 64'(busy), 64'd0);

    // Reset mid-frame (line 1), then a clean frame.
    plan_frame();
    b0 = beats_seen;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (beats_seen - b0 >= W + 2) hit = 1'b1;
    end
    check("t7_reach_line1", 64'(hit), 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t7_async_outs", 64'({busy, overflow, ctrl_we, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'd0);
    check("t7_async_ctrl_out", 64'(ctrl_out), 64'd0);
    exp_cmd.delete();
    exp_beat.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    plan_frame();
    pulse_start();
    wait_frame_done("t7");

    // Forced overflow: fill FIFO with stray words while blocked.
    @(negedge clk); tready_mode = 0;
    c0 = cmd_seen;
    plan_frame();
    pulse_start();
    repeat (60) @(negedge clk);
    check("t8_cmds", 64'(cmd_seen - c0), 64'd2);
    check("t8_no_overflow", 64'(overflow), 64'd0);
    ovf_allowed = 1'b1;
    extra = 2;
    repeat (10) @(negedge clk);
    check("t8_overflow_set", 64'(overflow), 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t8_overflow_reset", 64'({overflow, busy}), 64'd0);
    exp_cmd.delete();
    exp_beat.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ovf_allowed = 1'b0;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
